resp_reader: RTL and testbench
==============================

# resp_reader

Read-back engine for the learned frequency-response memory. After the learning controller has filled the RAM with one complex sample (real/imag) per frequency step, this block walks the RAM from address 0 to NUM_POINTS-1. It streams each sample out with its index and power |H|² over a valid/ready handshake, for the filter-recovery and display paths. It is the read-side counterpart of the learning controller's write port and sits on the RAM's read port in the clk_50m domain.

## Interface
Parameters:
- NUM_POINTS, 2751, number of RAM entries read per pass (addresses 0..NUM_POINTS-1)
- ADDR_W, 12, RAM address width

Ports:
- clk_50m  in  1  sole clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin one read pass
- learn_done  in  1  level; high = RAM contents valid and stable
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_real  in  16 signed  RAM real output, valid the cycle after rd_en
- rd_imag  in  16 signed  RAM imag output, valid the cycle after rd_en
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts beat
- m_real  out  16 signed  sample real part
- m_imag  out  16 signed  sample imag part
- m_power  out  32  unsigned m_real²+m_imag²
- m_index  out  ADDR_W  RAM address of the beat
- m_last  out  1  high on the beat with m_index = NUM_POINTS-1
- busy  out  1  high from accepted start until pass ends or aborts
- done  out  1  one-cycle pulse after the last beat handshake

## Operation
- State machine with states IDLE, READ and DRAIN:
  - IDLE: waits for a start pulse while learn_done=1, then goes to READ. start with learn_done=0 is ignored. start while busy is ignored.
  - READ: issues reads in address order. Moves to DRAIN once address NUM_POINTS-1 has been issued.
  - DRAIN: waits for every issued read to be delivered. After the m_last handshake it pulses done and returns to IDLE.
- The output buffer is a 2-entry FIFO with a registered head driving the m_* ports.
- rd_en is asserted only when (FIFO occupancy + reads in flight) < 2. This makes the buffer impossible to overflow under any m_ready pattern.
- Returned RAM data is pushed to the FIFO together with its index and power, computed as re*re + im*im (signed 16×16 products, unsigned 32-bit sum).
  - Worst case −32768/−32768 gives 0x8000_0000, with no overflow.
- A beat transfers when m_valid & m_ready are both high. m_* fields stay stable while m_valid=1 & m_ready=0.
- Abort: learn_done falling while busy flushes the FIFO and the in-flight read and returns to IDLE.
  - m_valid drops the next cycle.
  - Neither m_last nor done is generated.
- Reset values: all outputs 0, state IDLE, FIFO empty.

## Timing
- Start sampled at edge T0 → rd_en=1, rd_addr=0 during cycle T0+1.
- RAM data is captured at the edge ending T0+2. m_valid=1 with m_index=0 during T0+3, giving 3-cycle start-to-first-beat latency.
- With m_ready held high: one beat per cycle, no gaps.
  - Last beat (index NUM_POINTS-1) in cycle T0+NUM_POINTS+2.
  - done in the following cycle; busy low in the same cycle as done.
- When m_ready is low, at most 2 reads are outstanding. Reads resume the cycle after a handshake frees a slot.
- A start arriving on the same cycle that done pulses is ignored. A new pass needs start in IDLE.
- rd_addr holds its last issued value when rd_en=0. It returns to 0 on entering IDLE.

## Test plan
- RAM preloaded with real=addr, imag=−addr, m_ready=1, start → NUM_POINTS beats in consecutive cycles, first at T0+3.
  - Each beat has m_index=addr and m_power=2·addr².
  - m_last and done occur once at index 2750.
- m_ready toggling 1-0 pseudo-randomly → every index appears exactly once, in order, with no drop or duplicate. rd_en never leaves more than 2 entries pending.
- Entry holding real=−32768, imag=−32768 → m_power=0x8000_0000. Entry 0x7FFF/0x0000 → m_power=0x3FFF_0001.
- start with learn_done=0, and a second start mid-pass → no rd_en from the first case and no restart from the second; busy stays as before.
- learn_done dropped at beat 100 with m_ready=0 → m_valid low next cycle, busy low, no done. A subsequent start restarts from index 0.
- rst_n asserted mid-pass, asynchronously between edges → all outputs 0 immediately. State is IDLE after release.

Source files
------------

// File: rtl/resp_reader.sv
// Read-back engine for the learned frequency-response RAM.
// Streams each stored sample with its index and power over valid/ready.
module resp_reader #(
    parameter int NUM_POINTS = 2751,
    parameter int ADDR_W     = 12
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     learn_done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [15:0]       rd_real,
    input  logic signed [15:0]       rd_imag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [15:0]       m_real,
    output logic signed [15:0]       m_imag,
    output logic [31:0]              m_power,
    output logic [ADDR_W-1:0]        m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_POINTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [15:0]       re;
        logic [15:0]       im;
        logic [31:0]       pw;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } ent_t;

    state_t            state;
    state_t            state_nx;
    logic              done_nx;
    logic              ret_q;
    logic [ADDR_W-1:0] ret_idx;
    logic [1:0]        cnt;
    ent_t              head_q;
    ent_t              tail_q;
    ent_t              new_ent;
    logic              pop;
    logic              push;
    logic              abort;
    logic [2:0]        pend;
    logic signed [31:0] sq_re;
    logic signed [31:0] sq_im;

    assign busy    = (state != IDLE);
    assign m_valid = (cnt != 2'd0);
    assign m_real  = head_q.re;
    assign m_imag  = head_q.im;
    assign m_power = head_q.pw;
    assign m_index = head_q.idx;
    assign m_last  = head_q.last;

    assign pop   = m_valid & m_ready;
    assign abort = busy & ~learn_done;
    assign push  = ret_q & ~abort;

    // Slot freed by this cycle's pop is already usable, keeping full throughput.
    assign pend  = 3'(cnt) + 3'(ret_q) - 3'(pop);
    assign rd_en = (state == READ) & learn_done & (pend < 3'd2);

    // Squares of signed 16-bit values never exceed 2^30, so the sum fits.
    assign sq_re = rd_real * rd_real;
    assign sq_im = rd_imag * rd_imag;

    always_comb begin
        new_ent      = '0;
        new_ent.re   = rd_real;
        new_ent.im   = rd_imag;
        new_ent.pw   = unsigned'(sq_re) + unsigned'(sq_im);
        new_ent.idx  = ret_idx;
        new_ent.last = (ret_idx == LAST_ADDR);
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start & learn_done & ~done) state_nx = READ;
            end
            READ: begin
                if (rd_en && rd_addr == LAST_ADDR) state_nx = DRAIN;
            end
            DRAIN: begin
                state_nx = DRAIN;
            end
            default: state_nx = IDLE;
        endcase
        if (busy & pop & m_last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end
        if (abort) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            rd_addr <= '0;
            ret_q   <= 1'b0;
            ret_idx <= '0;
        end else begin
            state   <= state_nx;
            done    <= done_nx;
            ret_q   <= rd_en;
            ret_idx <= rd_addr;
            if (state_nx == IDLE) begin
                rd_addr <= '0;
            end else if (rd_en && rd_addr != LAST_ADDR) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (abort) begin
            cnt <= 2'd0;
        end else begin
            unique case (cnt)
                2'd0: begin
                    if (push) begin
                        head_q <= new_ent;
                        cnt    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push & pop) begin
                        head_q <= new_ent;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end else if (push) begin
                        tail_q <= new_ent;
                        cnt    <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) tail_q <= new_ent;
                        else cnt <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_reader.sv
// Bench for resp_reader: RAM model, stream scoreboard and directed cases.
module tb_resp_reader;

    localparam int N  = 2751;
    localparam int AW = 12;

    logic               clk_50m = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               learn_done = 1'b0;
    logic               m_ready = 1'b0;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic signed [15:0] rd_real = '0;
    logic signed [15:0] rd_imag = '0;
    logic               m_valid;
    logic signed [15:0] m_real;
    logic signed [15:0] m_imag;
    logic [31:0]        m_power;
    logic [AW-1:0]      m_index;
    logic               m_last;
    logic               busy;
    logic               done;

    resp_reader #(.NUM_POINTS(N), .ADDR_W(AW)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start),
        .learn_done(learn_done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_real(rd_real), .rd_imag(rd_imag), .m_valid(m_valid),
        .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_power(m_power), .m_index(m_index), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #10 clk_50m = ~clk_50m;

    logic signed [15:0] mem_re [N];
    logic signed [15:0] mem_im [N];

    always @(posedge clk_50m) begin
        if (rd_en) begin
            rd_real <= mem_re[rd_addr];
            rd_imag <= mem_im[rd_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic longint mpow(int i);
        return longint'(mem_re[i]) * mem_re[i] + longint'(mem_im[i]) * mem_im[i];
    endfunction

    bit      chk_en = 0;
    int      exp_idx, issued, accepted, issue_addr;
    int      hs_total, first_hs_cyc, last_hs_cyc, done_cnt, rd_cnt;
    bit      prev_last_hs, prev_stall, hs;
    longint  saved_data, saved_idx;
    longint  pw5, pw7, pw8, pw_last;

    always @(negedge clk_50m) begin
        if (!chk_en) begin
            exp_idx = 0; issued = 0; accepted = 0; issue_addr = 0;
            prev_last_hs = 0; prev_stall = 0;
        end else begin
            hs = m_valid && m_ready;
            chk("done_pulse", done, prev_last_hs);
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
            end
            if (prev_stall && m_valid) begin
                chk("stable_data", {m_real, m_imag, m_power}, saved_data);
                chk("stable_idx", {m_index, m_last}, saved_idx);
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, issue_addr);
                issue_addr++; issued++; rd_cnt++;
            end
            if (hs) begin
                chk("m_index", m_index, exp_idx);
                if (exp_idx < N) begin
                    chk("m_real", m_real, mem_re[exp_idx]);
                    chk("m_imag", m_imag, mem_im[exp_idx]);
                    chk("m_power", m_power, mpow(exp_idx));
                end
                chk("m_last", m_last, exp_idx == N - 1);
                if (hs_total == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (m_index == 5) pw5 = m_power;
                if (m_index == 7) pw7 = m_power;
                if (m_index == 8) pw8 = m_power;
                if (m_index == N - 1) pw_last = m_power;
                exp_idx++; accepted++; hs_total++;
            end
            chk("pending_le2", (issued - accepted) <= 2, 1);
            prev_last_hs = hs && m_last;
            prev_stall = m_valid && !m_ready;
            saved_data = {m_real, m_imag, m_power};
            saved_idx = {m_index, m_last};
            if (!busy && !m_valid) begin
                exp_idx = 0; issued = 0; accepted = 0; issue_addr = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_50m); #1;
    endtask

    task automatic run_pass(bit rnd, int restart_at);
        int k = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && k < 4 * N + 50) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (k == restart_at);
            if (k == restart_at + 2) chk("busy_mid", busy, 1);
            tick();
            k++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
    endtask

    int t0;
    int dc;

    initial begin
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 16'(i);
            mem_im[i] = 16'(-i);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        chk("rst_a", {rd_en, rd_addr, m_valid, busy, done, m_last}, 0);
        chk("rst_b", {m_real, m_imag, m_power}, 0);
        rst_n = 1'b1;
        learn_done = 1'b1;
        m_ready = 1'b1;
        chk_en = 1;
        tick();

        // Ramp pass: latency and gapless stream
        hs_total = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("lat_rd_en", rd_en, 1);
        chk("lat_rd_addr", rd_addr, 0);
        chk("lat_busy", busy, 1);
        tick();
        chk("lat_t2_valid", m_valid, 0);
        tick();
        chk("lat_t3_valid", m_valid, 1);
        chk("lat_t3_index", m_index, 0);
        begin
            int k = 0;
            while (!done && k < N + 20) begin tick(); k++; end
        end
        chk("done_seen", done, 1);
        tick();
        chk("ramp_beats", hs_total, N);
        chk("ramp_first", first_hs_cyc, t0 + 2);
        chk("ramp_last", last_hs_cyc, t0 + N + 1);
        chk("ramp_done_cnt", done_cnt, 1);
        chk("pow_idx5", pw5, 50);
        chk("pow_last", pw_last, 15125000);

        // Random data, random ready, restart attempt, corner powers
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 16'($urandom);
            mem_im[i] = 16'($urandom);
        end
        mem_re[7] = -16'sd32768; mem_im[7] = -16'sd32768;
        mem_re[8] = 16'sh7FFF;   mem_im[8] = 16'sh0000;
        hs_total = 0;
        run_pass(1'b1, 60);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_at_done", busy, 0);
        repeat (3) tick();
        chk("start_at_done2", busy, 0);
        chk("rand_beats", hs_total, N);
        chk("pow_min_min", pw7, 64'h8000_0000);
        chk("pow_max_zero", pw8, 64'h3FFF_0001);
        m_ready = 1'b1;

        // start without learn_done
        rd_cnt = 0;
        learn_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("nold_busy", busy, 0);
        chk("nold_rd", rd_cnt, 0);
        learn_done = 1'b1;
        repeat (3) tick();
        chk("nold_busy2", busy, 0);
        chk("nold_rd2", rd_cnt, 0);

        // Abort at beat 100 with downstream stalled
        hs_total = 0;
        dc = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int k = 0;
            while (!(m_valid && m_index == 100) && k < 400) begin tick(); k++; end
        end
        chk("abort_reach", {m_valid, m_index}, {1'b1, 12'd100});
        m_ready = 1'b0;
        tick();
        learn_done = 1'b0;
        tick();
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) tick();
        chk("abort_nodone", done_cnt, dc);
        chk("abort_beats", hs_total, 100);
        learn_done = 1'b1;
        m_ready = 1'b1;
        tick();
        hs_total = 0;
        run_pass(1'b0, -5);
        tick();
        chk("after_abort_beats", hs_total, N);

        // Asynchronous reset mid-pass
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        #5;
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_a", {rd_en, rd_addr, m_valid, busy, done, m_last}, 0);
        chk("arst_b", {m_real, m_imag, m_power}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {busy, m_valid, rd_en}, 0);
        chk_en = 1;
        hs_total = 0;
        run_pass(1'b0, -5);
        tick();
        chk("after_rst_beats", hs_total, N);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
